// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared states, BCD limits and field wrap helpers for the alarm set controller
package alarm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    T_HR,
    T_MIN,
    T_LD,
    A_HR,
    A_MIN,
    A_LD,
    SNZ_STOP,
    SNZ_LD
  } state_e;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  localparam bcd_time_t USER_ALARM_RST = '0;

  function automatic logic [5:0] bcd_hr_inc(input logic [1:0] h1, input logic [3:0] h0);
    if (h1 == 2'(HR_MAX / 10) && h0 == 4'(HR_MAX % 10)) begin
      return 6'd0;
    end else if (h0 == 4'd9) begin
      return {h1 + 2'd1, 4'd0};
    end else begin
      return {h1, h0 + 4'd1};
    end
  endfunction

  // Minute digits after adding 0..9 minutes, wrapping past MIN_MAX without touching hours.
  function automatic logic [7:0] bcd_min_add(input logic [3:0] m1, input logic [3:0] m0,
                                             input logic [3:0] add);
    logic [4:0] s0;
    logic [3:0] d1;
    logic [3:0] d0;
    s0 = {1'b0, m0} + {1'b0, add};
    if (s0 >= 5'd10) begin
      d0 = 4'(s0 - 5'd10);
      d1 = m1 + 4'd1;
    end else begin
      d0 = s0[3:0];
      d1 = m1;
    end
    if (d1 > 4'(MIN_MAX / 10)) begin
      d1 = 4'd0;
    end
    return {d1, d0};
  endfunction

  function automatic logic bcd_min_carry(input logic [3:0] m1, input logic [3:0] m0,
                                         input logic [3:0] add);
    logic [4:0] s0;
    s0 = {1'b0, m0} + {1'b0, add};
    return (s0 >= 5'd10) && (m1 == 4'(MIN_MAX / 10));
  endfunction

endpackage

// File: rtl/alarm_set_ctrl_if.sv
// rtl/alarm_set_ctrl_if.sv - load/time bus between the alarm set controller and the clock core
interface alarm_set_ctrl_if;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       AL_ON;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic       Alarm;

  modport master (
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
    input  H_out1, H_out0, M_out1, M_out0, Alarm
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
    output H_out1, H_out0, M_out1, M_out0, Alarm
  );
endinterface

// File: rtl/bcd_time_add.sv
// rtl/bcd_time_add.sv - combinational HH:MM plus 0..9 minutes with BCD hour and midnight wrap
module bcd_time_add
  import alarm_pkg::*;
(
  input  bcd_time_t  t_i,
  input  logic [3:0] add_i,
  output bcd_time_t  sum_o
);

  logic [7:0] min_r;
  logic       carry_r;
  logic [5:0] hr_r;

  always_comb begin
    min_r   = bcd_min_add(t_i.m1, t_i.m0, add_i);
    carry_r = bcd_min_carry(t_i.m1, t_i.m0, add_i);
    hr_r    = carry_r ? bcd_hr_inc(t_i.h1, t_i.h0) : {t_i.h1, t_i.h0};
    sum_o   = {hr_r, min_r};
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// rtl/alarm_set_ctrl.sv - button-driven time/alarm editor and snooze sequencer for the clock core
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZE  = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_snooze,
  input  logic             btn_alon,
  alarm_set_ctrl_if.master core,
  output logic [2:0]       edit_sel
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_e        state_q, state_d;
  logic [3:0]    btn_prev_q;
  logic [3:0]    btn_now, btn_edge;
  logic          btn_any;
  logic          snz_ev, mode_ev, inc_ev, alon_ev;
  bcd_time_t     edit_q, edit_d;
  bcd_time_t     shown_q, shown_d;
  bcd_time_t     ualarm_q, ualarm_d;
  bcd_time_t     core_time, snz_time, disp;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          reload_q, reload_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          al_on_q, al_on_d;
  logic          in_edit, timeout;

  assign btn_now   = {btn_snooze, btn_mode, btn_inc, btn_alon};
  assign btn_edge  = btn_now & ~btn_prev_q;
  assign btn_any   = |btn_edge;
  assign core_time = {core.H_out1, core.H_out0, core.M_out1, core.M_out0};

  // Snooze only outranks the other buttons where it can act; otherwise a held-through-reset
  // press of every button would lose the mode edge to an inert snooze.
  assign snz_ev  = btn_edge[3] && core.Alarm && (state_q == IDLE);
  assign mode_ev = btn_edge[2] && !snz_ev;
  assign inc_ev  = btn_edge[1] && !btn_edge[2] && !snz_ev;
  assign alon_ev = btn_edge[0] && !btn_edge[2] && !btn_edge[1] && !snz_ev;

  bcd_time_add u_snz_add (
    .t_i  (core_time),
    .add_i(4'(SNOOZE_MIN)),
    .sum_o(snz_time)
  );

  always_comb begin
    state_d  = state_q;
    edit_d   = edit_q;
    shown_d  = shown_q;
    ualarm_d = ualarm_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    al_on_d  = al_on_q;
    tmo_d    = '0;
    timeout  = 1'b0;
    in_edit  = state_q inside {T_HR, T_MIN, A_HR, A_MIN};
    if (in_edit) begin
      tmo_d   = btn_any ? '0 : tmo_q + TW'(1);
      timeout = !btn_any && (tmo_q == TW'(TIMEOUT_CYC - 1));
    end
    unique case (state_q)
      IDLE: begin
        if (snz_ev) begin
          state_d = SNZ_STOP;
          if (cnt_q >= CW'(MAX_SNOOZE)) begin
            edit_d   = ualarm_q;
            reload_d = 1'b1;
          end else begin
            edit_d   = snz_time;
            reload_d = 1'b0;
          end
        end else if (mode_ev) begin
          if (core.Alarm) begin
            state_d  = SNZ_STOP;
            edit_d   = ualarm_q;
            reload_d = 1'b1;
          end else begin
            state_d = T_HR;
            edit_d  = core_time;
          end
        end else if (alon_ev) begin
          al_on_d = !al_on_q;
        end
      end
      T_HR, A_HR: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (mode_ev) begin
          state_d = (state_q == T_HR) ? T_MIN : A_MIN;
        end else if (inc_ev) begin
          {edit_d.h1, edit_d.h0} = bcd_hr_inc(edit_q.h1, edit_q.h0);
        end
      end
      T_MIN, A_MIN: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (mode_ev) begin
          state_d = (state_q == T_MIN) ? T_LD : A_LD;
        end else if (inc_ev) begin
          {edit_d.m1, edit_d.m0} = bcd_min_add(edit_q.m1, edit_q.m0, 4'd1);
        end
      end
      T_LD: begin
        shown_d = edit_q;
        edit_d  = ualarm_q;
        state_d = A_HR;
      end
      A_LD: begin
        shown_d  = edit_q;
        ualarm_d = edit_q;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      SNZ_STOP: begin
        state_d = SNZ_LD;
      end
      SNZ_LD: begin
        shown_d = edit_q;
        cnt_d   = reload_q ? '0 : cnt_q + CW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      btn_prev_q <= '0;
      edit_q     <= '0;
      shown_q    <= '0;
      ualarm_q   <= USER_ALARM_RST;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      tmo_q      <= '0;
      al_on_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_now;
      edit_q     <= edit_d;
      shown_q    <= shown_d;
      ualarm_q   <= ualarm_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      tmo_q      <= tmo_d;
      al_on_q    <= al_on_d;
    end
  end

  // Digits follow the edit register while editing or loading, else the last loaded value.
  assign disp          = (state_q == IDLE) ? shown_q : edit_q;
  assign core.H_in1    = disp.h1;
  assign core.H_in0    = disp.h0;
  assign core.M_in1    = disp.m1;
  assign core.M_in0    = disp.m0;
  assign core.LD_time  = reset && (state_q == T_LD);
  assign core.LD_alarm = reset && ((state_q == A_LD) || (state_q == SNZ_LD));
  assign core.STOP_al  = reset && (state_q == SNZ_STOP);
  assign core.AL_ON    = al_on_q;

  assign edit_sel = {(state_q == T_HR) || (state_q == A_HR),
                     (state_q == T_MIN) || (state_q == A_MIN),
                     (state_q == A_HR) || (state_q == A_MIN)};

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// tb/tb_alarm_set_ctrl.sv - self-checking bench for alarm_set_ctrl against a minutes-of-day model
module tb_alarm_set_ctrl;

  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TMO  = 16;
  localparam int B_MODE = 0, B_INC = 1, B_SNZ = 2, B_ALON = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0, btn_alon = 1'b0;
  logic [2:0] edit_sel;

  alarm_set_ctrl_if cif ();

  alarm_set_ctrl #(
    .SNOOZE_MIN (SNZ),
    .MAX_SNOOZE (MAXS),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_snooze(btn_snooze),
    .btn_alon  (btn_alon),
    .core      (cif),
    .edit_sel  (edit_sel)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ualarm = 0, snz_cnt = 0, shown = 0;
  int cyc = 0, n_ldt = 0, n_lda = 0, n_stp = 0, n_ovl = 0;
  int ldt_val, lda_val, stp_val, ldt_cyc, lda_cyc, stp_cyc, ldt_prev, lda_prev;
  int prev_disp = 0;

  function automatic int disp();
    return (int'(cif.H_in1) * 10 + int'(cif.H_in0)) * 60 + int'(cif.M_in1) * 10 + int'(cif.M_in0);
  endfunction

  always @(negedge clk) begin
    int d;
    cyc++;
    d = disp();
    if (cif.LD_time === 1'b1) begin n_ldt++; ldt_val = d; ldt_cyc = cyc; ldt_prev = prev_disp; end
    if (cif.LD_alarm === 1'b1) begin n_lda++; lda_val = d; lda_cyc = cyc; lda_prev = prev_disp; end
    if (cif.STOP_al === 1'b1) begin n_stp++; stp_val = d; stp_cyc = cyc; end
    if (int'(cif.LD_time === 1'b1) + int'(cif.LD_alarm === 1'b1) + int'(cif.STOP_al === 1'b1) > 1) n_ovl++;
    prev_disp = d;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int t);
    cif.H_out1 = 2'((t / 60) / 10);
    cif.H_out0 = 4'((t / 60) % 10);
    cif.M_out1 = 4'((t % 60) / 10);
    cif.M_out0 = 4'(t % 10);
  endtask

  task automatic press(input int b);
    btn_mode   = (b == B_MODE);
    btn_inc    = (b == B_INC);
    btn_snooze = (b == B_SNZ);
    btn_alon   = (b == B_ALON);
    tick(1);
    {btn_mode, btn_inc, btn_snooze, btn_alon} = 4'b0;
    tick(1);
  endtask

  task automatic test_reset();
    cif.Alarm = 1'b0;
    set_time(11 * 60 + 26);
    reset = 1'b0;
    {btn_mode, btn_inc, btn_snooze, btn_alon} = 4'hF;
    tick(3);
    checks++; if (disp() !== 0) begin errors++; $display("FAIL reset_digits: got %0d expected 0", disp()); end
    checks++; if ({cif.LD_time, cif.LD_alarm, cif.STOP_al, cif.AL_ON} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {cif.LD_time, cif.LD_alarm, cif.STOP_al, cif.AL_ON}); end
    checks++; if (edit_sel !== 3'b000) begin errors++; $display("FAIL reset_edit_sel: got %b expected 000", edit_sel); end
    reset = 1'b1;
    tick(1);
    checks++; if (edit_sel !== 3'b100) begin errors++; $display("FAIL release_thr: got %b expected 100", edit_sel); end
    checks++; if (disp() !== 11 * 60 + 26) begin errors++; $display("FAIL release_preload: got %0d expected %0d", disp(), 11 * 60 + 26); end
    tick(3);
    checks++; if (edit_sel !== 3'b100) begin errors++; $display("FAIL release_one_edge: got %b expected 100", edit_sel); end
    {btn_mode, btn_inc, btn_snooze, btn_alon} = 4'b0;
    tick(TMO + 2);
    checks++; if (edit_sel !== 3'b000) begin errors++; $display("FAIL release_timeout: got %b expected 000", edit_sel); end
    checks++; if (n_ldt + n_lda + n_stp !== 0) begin errors++; $display("FAIL release_no_pulse: got %0d expected 0", n_ldt + n_lda + n_stp); end
  endtask

  task automatic test_alon();
    press(B_ALON);
    checks++; if (cif.AL_ON !== 1'b1) begin errors++; $display("FAIL alon_on: got %b expected 1", cif.AL_ON); end
    press(B_ALON);
    checks++; if (cif.AL_ON !== 1'b0) begin errors++; $display("FAIL alon_off: got %b expected 0", cif.AL_ON); end
  endtask

  task automatic test_time_set(input int t0, input int nh, input int nm, input int ah, input int am);
    int b_t, b_a, exp_t, exp_a;
    cif.Alarm = 1'b0;
    set_time(t0);
    b_t = n_ldt;
    b_a = n_lda;
    press(B_MODE);
    checks++; if (disp() !== t0) begin errors++; $display("FAIL tset_preload: got %0d expected %0d", disp(), t0); end
    repeat (nh) press(B_INC);
    press(B_MODE);
    repeat (nm) press(B_INC);
    press(B_MODE);
    exp_t = (((t0 / 60) + nh) % 24) * 60 + ((t0 % 60) + nm) % 60;
    checks++; if (n_ldt !== b_t + 1) begin errors++; $display("FAIL tset_ld_count: got %0d expected %0d", n_ldt, b_t + 1); end
    checks++; if (ldt_val !== exp_t) begin errors++; $display("FAIL tset_ld_value: got %0d expected %0d", ldt_val, exp_t); end
    checks++; if (ldt_prev !== exp_t) begin errors++; $display("FAIL tset_setup: got %0d expected %0d", ldt_prev, exp_t); end
    checks++; if (edit_sel !== 3'b101) begin errors++; $display("FAIL aset_enter: got %b expected 101", edit_sel); end
    checks++; if (disp() !== ualarm) begin errors++; $display("FAIL aset_preload: got %0d expected %0d", disp(), ualarm); end
    repeat (ah) press(B_INC);
    press(B_MODE);
    repeat (am) press(B_INC);
    press(B_MODE);
    exp_a = (((ualarm / 60) + ah) % 24) * 60 + ((ualarm % 60) + am) % 60;
    checks++; if (n_lda !== b_a + 1) begin errors++; $display("FAIL aset_ld_count: got %0d expected %0d", n_lda, b_a + 1); end
    checks++; if (lda_val !== exp_a || lda_prev !== exp_a) begin errors++; $display("FAIL aset_ld_value: got %0d/%0d expected %0d", lda_val, lda_prev, exp_a); end
    checks++; if (edit_sel !== 3'b000 || disp() !== exp_a) begin errors++; $display("FAIL aset_idle: got %b/%0d expected 000/%0d", edit_sel, disp(), exp_a); end
    checks++; if (n_ldt !== b_t + 1) begin errors++; $display("FAIL aset_no_ldtime: got %0d expected %0d", n_ldt, b_t + 1); end
    ualarm = exp_a;
    snz_cnt = 0;
    shown = exp_a;
  endtask

  task automatic test_snooze(input int t, input bit use_mode, input bit with_inc);
    int bs, ba, kc, exp;
    set_time(t);
    cif.Alarm = 1'b1;
    bs = n_stp;
    ba = n_lda;
    if (use_mode || snz_cnt >= MAXS) begin
      exp = ualarm;
      snz_cnt = 0;
    end else begin
      exp = (t + SNZ) % 1440;
      snz_cnt++;
    end
    kc = cyc + 1;
    if (use_mode) btn_mode = 1'b1; else btn_snooze = 1'b1;
    if (with_inc) btn_inc = 1'b1;
    tick(1);
    {btn_mode, btn_inc, btn_snooze, btn_alon} = 4'b0;
    tick(3);
    cif.Alarm = 1'b0;
    checks++; if (n_stp !== bs + 1 || n_lda !== ba + 1) begin errors++; $display("FAIL snz_counts: got stop=%0d ld=%0d expected %0d/%0d", n_stp, n_lda, bs + 1, ba + 1); end
    checks++; if (stp_cyc !== kc + 1 || lda_cyc !== kc + 2) begin errors++; $display("FAIL snz_timing: got %0d/%0d expected %0d/%0d", stp_cyc, lda_cyc, kc + 1, kc + 2); end
    checks++; if (stp_val !== exp || lda_val !== exp) begin errors++; $display("FAIL snz_target t=%0d: got %0d/%0d expected %0d", t, stp_val, lda_val, exp); end
    checks++; if (edit_sel !== 3'b000 || disp() !== exp) begin errors++; $display("FAIL snz_idle: got %b/%0d expected 000/%0d", edit_sel, disp(), exp); end
    shown = exp;
  endtask

  task automatic test_wrap();
    int b;
    cif.Alarm = 1'b0;
    set_time(23 * 60 + 59);
    b = n_ldt + n_lda;
    press(B_MODE);
    press(B_INC);
    checks++; if (disp() !== 59) begin errors++; $display("FAIL wrap_hour: got %0d expected 59", disp()); end
    press(B_MODE);
    press(B_INC);
    checks++; if (disp() !== 0) begin errors++; $display("FAIL wrap_minute: got %0d expected 0", disp()); end
    tick(TMO + 2);
    checks++; if (edit_sel !== 3'b000 || disp() !== shown) begin errors++; $display("FAIL wrap_discard: got %b/%0d expected 000/%0d", edit_sel, disp(), shown); end
    checks++; if (n_ldt + n_lda !== b) begin errors++; $display("FAIL wrap_no_load: got %0d expected %0d", n_ldt + n_lda, b); end
  endtask

  task automatic test_timeout();
    int b;
    cif.Alarm = 1'b0;
    set_time(int'($urandom_range(0, 1439)));
    b = n_ldt + n_lda + n_stp;
    press(B_MODE);
    press(B_MODE);
    cif.Alarm = 1'b1;
    tick(TMO - 2);
    checks++; if (edit_sel !== 3'b010) begin errors++; $display("FAIL timeout_early: got %b expected 010", edit_sel); end
    tick(1);
    checks++; if (edit_sel !== 3'b000) begin errors++; $display("FAIL timeout_exit: got %b expected 000", edit_sel); end
    tick(2);
    checks++; if (n_ldt + n_lda + n_stp !== b) begin errors++; $display("FAIL timeout_no_pulse: got %0d expected %0d", n_ldt + n_lda + n_stp, b); end
    cif.Alarm = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b;
    cif.Alarm = 1'b0;
    b = n_ldt;
    press(B_MODE);
    press(B_MODE);
    btn_mode = 1'b1;
    tick(1);
    btn_mode = 1'b0;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++; if (n_ldt !== b) begin errors++; $display("FAIL reset_mid_pulse: got %0d expected %0d", n_ldt, b); end
    checks++; if (edit_sel !== 3'b000 || disp() !== 0) begin errors++; $display("FAIL reset_mid_state: got %b/%0d expected 000/0", edit_sel, disp()); end
    ualarm = 0;
    snz_cnt = 0;
    shown = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alon();
    repeat (2) begin
      test_time_set(int'($urandom_range(0, 1439)), int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 70)), int'($urandom_range(0, 30)),
                    int'($urandom_range(0, 70)));
    end
    test_time_set(11 * 60 + 26, 1, 3, (6 - ualarm / 60 + 24) % 24, (30 - ualarm % 60 + 60) % 60);
    test_snooze(23 * 60 + 57, 1'b0, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b0, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b0, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b0, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b0, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b1, 1'b0);
    test_snooze(int'($urandom_range(0, 1439)), 1'b0, 1'b1);
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_snooze(int'($urandom_range(0, 1439)), 1'b1, 1'b0);
    checks++; if (n_ovl !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", n_ovl); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
